// File: rtl/rv32i_pkg.sv
// Shared rv32i constants and types used by the writeback arbiter and scoreboard.
package rv32i_pkg;

  localparam int NUM_WB_SRC = 3;
  localparam int REG_AW     = 5;
  localparam int XLEN       = 32;

  localparam int SRC_PIPE = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_MDU  = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module rv32i_scoreboard
  import rv32i_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set,
  input  reg_addr_t set_rd,
  input  logic      clr,
  input  reg_addr_t clr_rd,
  input  reg_addr_t chk_rs1,
  input  reg_addr_t chk_rs2,
  input  reg_addr_t chk_rd,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy
);

  logic [31:0] pend_q;
  logic [31:0] pend_nxt;

  // Clear is applied first so a same-cycle set of the same register wins.
  always_comb begin
    pend_nxt = pend_q;
    if (clr) pend_nxt[clr_rd] = 1'b0;
    if (set) pend_nxt[set_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end

  assign rs1_busy = pend_q[chk_rs1];
  assign rs2_busy = pend_q[chk_rs2];
  assign rd_busy  = pend_q[chk_rd];

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Writeback arbiter for the single regfile write port, with starvation guard
// and a scoreboard of long-latency destinations still in flight.
module rv32i_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WB_SRC-1:0]        req_valid,
  input  logic [NUM_WB_SRC*REG_AW-1:0] req_rd,
  input  logic [NUM_WB_SRC*XLEN-1:0]   req_data,
  output logic [NUM_WB_SRC-1:0]        req_ready,
  output logic                         rf_we,
  output logic [REG_AW-1:0]            rf_waddr,
  output logic [XLEN-1:0]              rf_wdata,
  input  logic                         sb_set,
  input  logic [REG_AW-1:0]            sb_set_rd,
  input  logic [REG_AW-1:0]            chk_rs1,
  input  logic [REG_AW-1:0]            chk_rs2,
  input  logic [REG_AW-1:0]            chk_rd,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         rd_busy
);

  localparam logic       RR_LOAD    = 1'b0;
  localparam logic       RR_MDU     = 1'b1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic                  rr_ptr;
  logic [7:0]            starve_cnt;
  logic                  hi_req;
  logic                  starved;
  logic [NUM_WB_SRC-1:0] grant;
  logic                  vld_p0;
  reg_addr_t             sel_rd_p0;
  xword_t                sel_data_p0;

  assign hi_req  = req_valid[SRC_LOAD] | req_valid[SRC_MDU];
  assign starved = hi_req && (starve_cnt == STARVE_LIM);

  // Stage p0: grant selection and source mux
  always_comb begin
    grant = '0;
    if (!rst_n) begin
      grant = '0;
    end else if (req_valid[SRC_PIPE] && !starved) begin
      grant[SRC_PIPE] = 1'b1;
    end else if (rr_ptr == RR_MDU) begin
      if (req_valid[SRC_MDU])       grant[SRC_MDU]  = 1'b1;
      else if (req_valid[SRC_LOAD]) grant[SRC_LOAD] = 1'b1;
    end else begin
      if (req_valid[SRC_LOAD])      grant[SRC_LOAD] = 1'b1;
      else if (req_valid[SRC_MDU])  grant[SRC_MDU]  = 1'b1;
    end
  end

  assign req_ready = grant;
  assign vld_p0    = |grant;

  always_comb begin
    sel_rd_p0   = req_rd[SRC_PIPE*REG_AW +: REG_AW];
    sel_data_p0 = req_data[SRC_PIPE*XLEN +: XLEN];
    if (grant[SRC_LOAD]) begin
      sel_rd_p0   = req_rd[SRC_LOAD*REG_AW +: REG_AW];
      sel_data_p0 = req_data[SRC_LOAD*XLEN +: XLEN];
    end
    if (grant[SRC_MDU]) begin
      sel_rd_p0   = req_rd[SRC_MDU*REG_AW +: REG_AW];
      sel_data_p0 = req_data[SRC_MDU*XLEN +: XLEN];
    end
  end

  // Stage p1: registered regfile write port and arbitration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rr_ptr     <= RR_LOAD;
      starve_cnt <= '0;
    end else begin
      rf_we <= vld_p0 && (sel_rd_p0 != '0);
      if (vld_p0) begin
        rf_waddr <= sel_rd_p0;
        rf_wdata <= sel_data_p0;
      end
      if ((grant[SRC_LOAD] && rr_ptr == RR_LOAD) || (grant[SRC_MDU] && rr_ptr == RR_MDU))
        rr_ptr <= ~rr_ptr;
      if (grant[SRC_LOAD] || grant[SRC_MDU] || !hi_req)
        starve_cnt <= '0;
      else if (grant[SRC_PIPE] && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  rv32i_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (sb_set),
    .set_rd   (sb_set_rd),
    .clr      (rf_we),
    .clr_rd   (rf_waddr),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .chk_rd   (chk_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Randomized and directed bench for rv32i_wb_arbiter against a behavioural model.
module tb_rv32i_wb_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        rs1_busy, rs2_busy, rd_busy;

  always #5 clk = ~clk;

  rv32i_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sb_set    (sb_set),
    .sb_set_rd (sb_set_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_busy   (rd_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // stimulus for the next cycle
  logic [2:0]  s_valid;
  logic [4:0]  s_rd [3];
  logic [31:0] s_data [3];
  logic        s_set;
  logic [4:0]  s_setrd, s_c1, s_c2, s_cd;

  // reference model state
  bit [31:0] m_pend;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_fav;
  int        m_starve;

  logic [2:0] last_ready;
  logic       last_b1;

  task automatic model_reset();
    m_pend = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
    m_fav = 1; m_starve = 0;
  endtask

  function automatic int model_winner(input logic [2:0] v);
    bit others;
    others = v[1] | v[2];
    if (v[0] && !(others && m_starve == STARVE_MAX)) return 0;
    if (v[m_fav]) return m_fav;
    if (v[3 - m_fav]) return 3 - m_fav;
    return -1;
  endfunction

  task automatic model_step(input int w);
    bit others;
    others = s_valid[1] | s_valid[2];
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (s_set && s_setrd != 0) m_pend[s_setrd] = 1'b1;
    if (w >= 0) begin
      m_we = (s_rd[w] != 0); m_waddr = s_rd[w]; m_wdata = s_data[w];
    end else begin
      m_we = 1'b0;
    end
    if (w > 0 && w == m_fav) m_fav = 3 - m_fav;
    if (w > 0 || !others) m_starve = 0;
    else if (w == 0 && m_starve < STARVE_MAX) m_starve++;
  endtask

  task automatic idle();
    s_valid = '0; s_set = 0; s_setrd = '0; s_c1 = '0; s_c2 = '0; s_cd = '0;
    for (int i = 0; i < 3; i++) begin
      s_rd[i] = '0; s_data[i] = '0;
    end
  endtask

  task automatic drive();
    req_valid = s_valid;
    req_rd    = {s_rd[2], s_rd[1], s_rd[0]};
    req_data  = {s_data[2], s_data[1], s_data[0]};
    sb_set    = s_set;
    sb_set_rd = s_setrd;
    chk_rs1   = s_c1;
    chk_rs2   = s_c2;
    chk_rd    = s_cd;
  endtask

  task automatic tick();
    int w;
    logic [2:0] exp;
    @(negedge clk);
    drive();
    #1;
    if (s_set && s_setrd != 0 && m_pend[s_setrd] && !(m_we && m_waddr == s_setrd))
      $error("set on pending register x%0d", s_setrd);
    w = model_winner(s_valid);
    exp = (w >= 0) ? 3'(1 << w) : 3'b000;
    last_ready = req_ready;
    last_b1 = rs1_busy;
    check_eq("ready", 32'(req_ready), 32'(exp));
    check_eq("rs1_busy", 32'(rs1_busy), 32'(m_pend[s_c1]));
    check_eq("rs2_busy", 32'(rs2_busy), 32'(m_pend[s_c2]));
    check_eq("rd_busy", 32'(rd_busy), 32'(m_pend[s_cd]));
    @(posedge clk);
    model_step(w);
    #1;
    check_eq("rf_we", 32'(rf_we), 32'(m_we));
    check_eq("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check_eq("rf_wdata", rf_wdata, m_wdata);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    s_valid = 3'b111;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    drive();
    tick();
    check_eq("idle_ready", 32'(last_ready), 32'd0);

    // fixed priority of port 0
    s_valid = 3'b111; s_rd[0] = 5; s_rd[1] = 6; s_rd[2] = 7;
    for (int i = 0; i < 3; i++) s_data[i] = $urandom;
    tick();
    check_eq("prio_ready", 32'(last_ready), 32'd1);
    check_eq("prio_we", 32'(rf_we), 32'd1);
    check_eq("prio_waddr", 32'(rf_waddr), 32'd5);
    check_eq("prio_wdata", rf_wdata, s_data[0]);

    // round-robin between ports 1 and 2
    s_valid = 3'b110;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rr_ready", 32'(last_ready), (i % 2) ? 32'd4 : 32'd2);
      check_eq("rr_waddr", 32'(rf_waddr), (i % 2) ? 32'd7 : 32'd6);
    end

    // starvation guard
    s_valid = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq("starve_ready", 32'(last_ready), (i == 9) ? 32'd2 : 32'd1);
    end

    // scoreboard life cycle of x10
    idle();
    s_set = 1; s_setrd = 10; s_c1 = 10;
    tick();
    s_set = 0;
    tick();
    check_eq("sb_busy_set", 32'(last_b1), 32'd1);
    s_valid = 3'b010; s_rd[1] = 10; s_data[1] = 32'hDEADBEEF;
    tick();
    check_eq("sb_commit_data", rf_wdata, 32'hDEADBEEF);
    check_eq("sb_commit_we", 32'(rf_we), 32'd1);
    s_valid = '0;
    tick();
    check_eq("sb_busy_commit", 32'(last_b1), 32'd1);
    tick();
    check_eq("sb_busy_after", 32'(last_b1), 32'd0);

    // set and clear of x10 in the same cycle
    s_set = 1; s_setrd = 10;
    tick();
    s_set = 0; s_valid = 3'b010;
    tick();
    s_valid = '0; s_set = 1;
    tick();
    s_set = 0;
    tick();
    check_eq("sb_setclr_busy", 32'(last_b1), 32'd1);
    s_valid = 3'b010;
    tick();
    s_valid = '0;
    tick();
    tick();
    check_eq("sb_clear_busy", 32'(last_b1), 32'd0);

    // writes and sets to x0
    idle();
    s_valid = 3'b100; s_rd[2] = 0; s_data[2] = 32'h1234_5678;
    tick();
    check_eq("x0_ready", 32'(last_ready), 32'd4);
    check_eq("x0_we", 32'(rf_we), 32'd0);
    idle();
    s_set = 1; s_setrd = 0;
    tick();
    s_set = 0;
    tick();
    check_eq("x0_busy", 32'(last_b1), 32'd0);

    // asynchronous reset between handshake and commit
    s_set = 1; s_setrd = 12; s_c1 = 12;
    tick();
    s_set = 0; s_valid = 3'b001; s_rd[0] = 3; s_data[0] = $urandom;
    tick();
    check_eq("arst_pre_we", 32'(rf_we), 32'd1);
    @(negedge clk);
    s_valid = 3'b010; s_rd[1] = 12; s_data[1] = $urandom;
    drive();
    #1;
    check_eq("arst_hs_ready", 32'(req_ready), 32'd2);
    check_eq("arst_pre_busy", 32'(rs1_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_we", 32'(rf_we), 32'd0);
    check_eq("arst_ready", 32'(req_ready), 32'd0);
    check_eq("arst_busy", 32'(rs1_busy), 32'd0);
    check_eq("arst_waddr", 32'(rf_waddr), 32'd0);
    @(posedge clk);
    #1;
    check_eq("arst_we_hold", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    s_c1 = 12;
    drive();
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      s_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        s_rd[i] = 5'($urandom_range(0, 15));
        s_data[i] = $urandom;
      end
      s_set = ($urandom_range(0, 3) == 0);
      s_setrd = 5'($urandom_range(0, 15));
      if (s_set && m_pend[s_setrd] && !(m_we && m_waddr == s_setrd)) s_set = 0;
      s_c1 = 5'($urandom_range(0, 15));
      s_c2 = 5'($urandom_range(0, 15));
      s_cd = 5'($urandom_range(0, 31));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
# rv32i_wb_arbiter

Writeback arbiter and register scoreboard for the rv32i_regfile single write port. It sits between the three writeback sources and the register file: the in-order pipeline, the load unit and the multi-cycle mul/div unit. Each cycle it grants one source, registers the write onto the regfile port, and tracks destination registers with long-latency writes still outstanding so decode can stall on RAW/WAW hazards.

## Interface
- STARVE_MAX, default 8: consecutive denied cycles of a pending port-1/2 request before port 0 is held off; legal 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  3  per-source write request; [0]=pipeline, [1]=load unit, [2]=mul/div.
- req_rd  in  15  destination register, 5 bits per source, source i at [5i+4:5i].
- req_data  in  96  write data, source i at [32i+31:32i].
- req_ready  out  3  grant; transfer on valid & ready in the same cycle.
- rf_we  out  1  regfile write enable, registered.
- rf_waddr  out  5  regfile write address, registered.
- rf_wdata  out  32  regfile write data, registered.
- sb_set  in  1  decode issues a long-latency op (load or mul/div) writing sb_set_rd.
- sb_set_rd  in  5  destination being marked pending.
- chk_rs1, chk_rs2, chk_rd  in  5 each  decode register addresses to check.
- rs1_busy, rs2_busy, rd_busy  out  1 each  scoreboard bit for each checked address; combinational from state.

## Operation
- Arbitration: at most one grant per cycle; req_ready is one-hot or zero and depends on the current req_valid and state only.
- Port 0 has fixed highest priority. Ports 1 and 2 share round-robin priority through rr_ptr, which names the favoured port. rr_ptr toggles to the other port after the favoured port is granted.
- Starvation guard: starve_cnt increments each cycle in which port 0 wins while port 1 or 2 is valid. It saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX, port 0 gets ready=0 and the round-robin winner among ports 1 and 2 is granted.
  - starve_cnt clears on any port-1/2 grant, or in any cycle with no port-1/2 request.
- Commit: on a transfer, rf_we<=1, rf_waddr<=rd, rf_wdata<=data at the next edge. rf_we is held 0 when rd==0; the transfer is still accepted.
- With no transfer: rf_we<=0. rf_waddr and rf_wdata hold their last values.
- Scoreboard: 32-bit pending vector; bit 0 is constant 0.
  - Set: sb_set & sb_set_rd!=0 sets the bit at the edge.
  - Clear: rf_we=1 clears bit rf_waddr at the edge, which is the same edge the regfile captures the data.
  - Set and clear of the same register in the same cycle: set wins, and the bit stays 1.
  - Setting an already-set bit leaves it at 1. Decode must stall on rd_busy; the bench asserts that set-on-set never occurs.
- Busy outputs: rsX_busy = pending[chk_rsX], rd_busy = pending[chk_rd]. An address of 0 always reads 0.

## Timing
- Reset (async assert, sync release):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0, rr_ptr=port 1, starve_cnt=0.
  - req_ready=0 while rst_n=0.
- Latency: handshake in cycle N gives rf_* driven in N+1. The regfile captures at the end of N+1. The value is readable in N+2, and the scoreboard bit reads 0 in N+2.
- Bypass: none. A register is busy until the cycle after commit.
- Reset mid-operation: any granted but uncommitted write is dropped, and all pending bits clear.
- Throughput: one write per cycle, with no bubbles between back-to-back grants.

## Structure
- Shared package rv32i_pkg holds:
  - source index constants: SRC_PIPE=0, SRC_LOAD=1, SRC_MDU=2;
  - NUM_WB_SRC=3;
  - REG_AW=5 and XLEN=32.
- One natural sub-module: rv32i_scoreboard, containing the pending vector, the set/clear logic and the three check ports. The arbiter, starvation counter and write register live in the top.

## Test plan
- Reset then idle: after rst_n release, rf_we=0, every busy output=0, req_ready=0 with no valids.
- Priority: in one cycle, req_valid=3'b111, rd0=5, rd1=6, rd2=7. Expected: ready=3'b001, and next cycle rf_we=1, waddr=5, wdata=data0.
- Round-robin: hold valid=3'b110 for 4 cycles. Expected grants 1,2,1,2 and waddr sequence 6,7,6,7.
- Starvation, STARVE_MAX=8: hold valid=3'b011 continuously. Expected: port 0 granted for 8 cycles, port 1 granted in cycle 9, port 0 again from cycle 10.
- Scoreboard life cycle:
  - sb_set rd=10 with chk_rs1=10. rs1_busy=1 from the next cycle.
  - Load unit writes rd=10 with data 0xDEADBEEF. rs1_busy stays 1 during the commit cycle and drops to 0 after it; the regfile then reads 0xDEADBEEF.
  - Same-cycle set and clear of x10: busy stays 1.
- x0 handling: port 2 writes rd=0. It is accepted (ready=1), rf_we stays 0, and sb_set rd=0 leaves rs busy=0 for chk=0.
- Async reset mid-write: assert rst_n=0 between handshake and commit. rf_we=0 immediately, and pending is cleared.
